// File: rtl/scard_t0_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scard_t0_ctrl
//  Description : ISO 7816-3 T=0 command sequencer. It sends the APDU header
//                from a command buffer, decodes procedure bytes, moves data
//                to or from the card, and captures SW1/SW2 and response bytes.
//                Optional work-wait timer: define SCARD_T0_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module scard_t0_ctrl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd3571200
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [8:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       cmd_we,
    input  logic       dir_in,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] sw1,
    output logic [7:0] sw2,
    output logic [8:0] rsp_len,
    output logic       err_timeout,
    output logic       err_proto,
    input  logic [7:0] rsp_addr,
    output logic [7:0] rsp_data,
    input  logic       scardfifo_rxe,
    input  logic       scardfifo_txf,
    input  logic       scardfifo_txe,
    input  logic [7:0] scardfifo_din,
    output logic       scardfifo_rd,
    output logic       scardfifo_wr,
    output logic [7:0] scardfifo_dout
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HDR       = 4'd1,
        ST_WAIT_PROC = 4'd2,
        ST_PROC      = 4'd3,
        ST_XFER_ALL  = 4'd4,
        ST_XFER_ONE  = 4'd5,
        ST_SW2       = 4'd6,
        ST_DONE      = 4'd7
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_phase, w_phase_nxt;   // 0: fetch/pop, 1: push/sample
    logic       w_rd, w_wr;

    logic [7:0] r_cmd_mem [0:511];
    logic [7:0] r_rsp_mem [0:255];
    logic [7:0] r_cmd_rdata;
    logic [8:0] r_ptr;                  // command buffer index of next push
    logic [8:0] r_rem;                  // data bytes still to move
    logic [7:0] r_ins;
    logic       r_dir;
    logic [7:0] r_sw1, r_sw2;
    logic [8:0] r_rsp_len;
    logic       r_err_proto;
    logic [7:0] r_rsp_data;

    logic       w_accept, w_xfer, w_one, w_rsp_we, w_timeout;
    logic       w_pb_null, w_pb_ack, w_pb_nack, w_pb_sw;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_xfer    = (r_state == ST_XFER_ALL) || (r_state == ST_XFER_ONE);
    assign w_one     = (r_state == ST_XFER_ONE);
    assign w_rsp_we  = w_xfer && r_dir && r_phase && (r_rem != 9'd0);

    // Procedure byte classes; NULL is tested first so 0x60 never lands in SW1
    assign w_pb_null = (scardfifo_din == 8'h60);
    assign w_pb_ack  = (scardfifo_din == r_ins);
    assign w_pb_nack = (scardfifo_din == ~r_ins);
    assign w_pb_sw   = (scardfifo_din[7:4] == 4'h6) || (scardfifo_din[7:4] == 4'h9);

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= (w_state_nxt != r_state) ? 1'b0 : w_phase_nxt;
        end
    end

    // Next-state and FIFO strobes
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else if (!scardfifo_txf) begin
                    w_wr        = 1'b1;
                    w_phase_nxt = 1'b0;
                    if (r_ptr == 9'd4) w_state_nxt = ST_WAIT_PROC;
                end
            end
            ST_WAIT_PROC: begin
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (!scardfifo_rxe) begin
                    w_rd        = 1'b1;
                    w_state_nxt = ST_PROC;
                end
            end
            ST_PROC: begin
                if (w_pb_null)      w_state_nxt = ST_WAIT_PROC;
                else if (w_pb_ack)  w_state_nxt = ST_XFER_ALL;
                else if (w_pb_nack) w_state_nxt = ST_XFER_ONE;
                else if (w_pb_sw)   w_state_nxt = ST_SW2;
                else                w_state_nxt = ST_DONE;
            end
            ST_XFER_ALL, ST_XFER_ONE: begin
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (r_rem == 9'd0) begin
                    w_state_nxt = ST_WAIT_PROC;
                end else if (!r_dir) begin
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else if (!scardfifo_txf) begin
                        w_wr        = 1'b1;
                        w_phase_nxt = 1'b0;
                        if (w_one || (r_rem == 9'd1)) w_state_nxt = ST_WAIT_PROC;
                    end
                end else begin
                    if (!r_phase) begin
                        if (!scardfifo_rxe) begin
                            w_rd        = 1'b1;
                            w_phase_nxt = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = 1'b0;
                        if (w_one || (r_rem == 9'd1)) w_state_nxt = ST_WAIT_PROC;
                    end
                end
            end
            ST_SW2: begin
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (!r_phase) begin
                    if (!scardfifo_rxe) begin
                        w_rd        = 1'b1;
                        w_phase_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Transaction datapath: pointers, counters, status capture
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ptr       <= 9'd0;
            r_rem       <= 9'd0;
            r_ins       <= 8'h00;
            r_dir       <= 1'b0;
            r_sw1       <= 8'h00;
            r_sw2       <= 8'h00;
            r_rsp_len   <= 9'd0;
            r_err_proto <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr       <= 9'd0;
                r_rem       <= 9'd0;
                r_dir       <= dir_in;
                r_sw1       <= 8'h00;
                r_sw2       <= 8'h00;
                r_rsp_len   <= 9'd0;
                r_err_proto <= 1'b0;
            end
            if (w_wr) r_ptr <= r_ptr + 9'd1;
            if ((r_state == ST_HDR) && r_phase && (r_ptr == 9'd1)) r_ins <= r_cmd_rdata;
            // P3 = 0 means 256 bytes only when the card is sending
            if ((r_state == ST_HDR) && w_wr && (r_ptr == 9'd4)) begin
                if (r_cmd_rdata == 8'h00) r_rem <= r_dir ? 9'd256 : 9'd0;
                else                      r_rem <= {1'b0, r_cmd_rdata};
            end
            if (w_xfer && (w_wr || w_rsp_we)) r_rem <= r_rem - 9'd1;
            if (w_rsp_we) r_rsp_len <= r_rsp_len + 9'd1;
            if ((r_state == ST_PROC) && !w_pb_null && !w_pb_ack && !w_pb_nack) begin
                if (w_pb_sw) r_sw1       <= scardfifo_din;
                else         r_err_proto <= 1'b1;
            end
            if ((r_state == ST_SW2) && r_phase) r_sw2 <= scardfifo_din;
        end
    end

    // Command buffer: host writes only while idle; read port follows r_ptr
    always_ff @(posedge clk_i) begin
        if (cmd_we && !busy) r_cmd_mem[cmd_addr] <= cmd_data;
        r_cmd_rdata <= r_cmd_mem[r_ptr];
    end

    // Response buffer write from the RX FIFO
    always_ff @(posedge clk_i) begin
        if (w_rsp_we) r_rsp_mem[r_rsp_len[7:0]] <= scardfifo_din;
    end

    // Registered response read port
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_rsp_data <= 8'h00;
        else            r_rsp_data <= r_rsp_mem[rsp_addr];
    end

`ifdef SCARD_T0_TIMEOUT_EN
    logic [23:0] r_timer;
    logic        r_err_timeout;
    logic        w_count_st;

    assign w_count_st = (r_state == ST_WAIT_PROC) || (r_state == ST_SW2) || (w_xfer && r_dir);
    assign w_timeout  = w_count_st && (r_timer >= TIMEOUT_CYCLES);

    // Work-wait timer: runs only while both FIFOs are idle, cleared by any pop
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_timer       <= 24'd0;
            r_err_timeout <= 1'b0;
        end else begin
            if (!w_count_st || w_rd)
                r_timer <= 24'd0;
            else if (scardfifo_rxe && scardfifo_txe && !w_timeout)
                r_timer <= r_timer + 24'd1;
            if (w_accept)       r_err_timeout <= 1'b0;
            else if (w_timeout) r_err_timeout <= 1'b1;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_txe;
    assign w_unused_txe = scardfifo_txe;
    assign w_timeout    = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    assign busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done           = (r_state == ST_DONE);
    assign sw1            = r_sw1;
    assign sw2            = r_sw2;
    assign rsp_len        = r_rsp_len;
    assign err_proto      = r_err_proto;
    assign rsp_data       = r_rsp_data;
    assign scardfifo_rd   = w_rd;
    assign scardfifo_wr   = w_wr;
    assign scardfifo_dout = w_wr ? r_cmd_rdata : 8'h00;

endmodule
`default_nettype wire
